// File: rtl/openfire_mem_ctrl.sv
// openfire_mem_ctrl: arbitrates the openfire CPU instruction and data ports
// onto one single-port synchronous RAM with one-cycle read latency. Each
// access walks IDLE -> ISSUE -> CAPTURE -> DONE, performs big-endian byte and
// halfword lane steering, and returns a one-cycle done pulse to its requester.
module openfire_mem_ctrl #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           imem_addr,
    input  logic                  imem_re,
    output logic [31:0]           imem_data_in,
    output logic                  imem_done,
    input  logic [31:0]           dmem_addr,
    input  logic [31:0]           dmem_data_out,
    input  logic                  dmem_we,
    input  logic                  dmem_re,
    input  logic [1:0]            dmem_input_sel,
    output logic [31:0]           dmem_data_in,
    output logic                  dmem_done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [3:0]            ram_be,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    localparam logic GRANT_IMEM = 1'b0;
    localparam logic GRANT_DMEM = 1'b1;

    state_t                state_q, state_d;
    logic                  lastGrant_q, lastGrant_d;
    logic                  grantDmem_q, grantDmem_d;
    logic                  isRead_q, isRead_d;
    logic [1:0]            size_q, size_d;
    logic [1:0]            offset_q, offset_d;
    logic [ADDR_WIDTH-1:0] ramAddr_q, ramAddr_d;
    logic                  ramEn_q, ramEn_d;
    logic                  ramWe_q, ramWe_d;
    logic [3:0]            ramBe_q, ramBe_d;
    logic [31:0]           ramWdata_q, ramWdata_d;
    logic [31:0]           imemData_q, imemData_d;
    logic [31:0]           dmemData_q, dmemData_d;
    logic                  imemDone_q, imemDone_d;
    logic                  dmemDone_q, dmemDone_d;

    logic                  dmemReq;
    logic                  grantValid;
    logic                  grantDmem;
    logic [31:0]           steered;
    logic                  unusedBits;

    assign dmemReq    = dmem_re | dmem_we;
    assign unusedBits = ^{imem_addr[31:ADDR_WIDTH+2], imem_addr[1:0],
                          dmem_addr[31:ADDR_WIDTH+2]};

    // State register; reset returns to IDLE and hands the first tie to dmem.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic with round-robin arbitration sampled only in IDLE.
    always_comb begin
        state_d    = state_q;
        grantValid = 1'b0;
        grantDmem  = 1'b0;
        case (state_q)
            IDLE: begin
                if (imem_re || dmemReq) begin
                    grantValid = 1'b1;
                    grantDmem  = dmemReq && (!imem_re || (lastGrant_q == GRANT_IMEM));
                    state_d    = ISSUE;
                end
            end
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Big-endian read steering of the RAM word for the latched size and offset.
    always_comb begin
        steered = ram_rdata;
        case (size_q)
            2'b01: steered = {16'h0000, offset_q[1] ? ram_rdata[15:0] : ram_rdata[31:16]};
            2'b10: begin
                case (offset_q)
                    2'd0:    steered = {24'h000000, ram_rdata[31:24]};
                    2'd1:    steered = {24'h000000, ram_rdata[23:16]};
                    2'd2:    steered = {24'h000000, ram_rdata[15:8]};
                    default: steered = {24'h000000, ram_rdata[7:0]};
                endcase
            end
            default: steered = ram_rdata;
        endcase
    end

    // Output logic: load RAM command on grant, capture read data and done flags.
    always_comb begin
        lastGrant_d = lastGrant_q;
        grantDmem_d = grantDmem_q;
        isRead_d    = isRead_q;
        size_d      = size_q;
        offset_d    = offset_q;
        ramAddr_d   = ramAddr_q;
        ramEn_d     = 1'b0;
        ramWe_d     = 1'b0;
        ramBe_d     = ramBe_q;
        ramWdata_d  = ramWdata_q;
        imemData_d  = imemData_q;
        dmemData_d  = dmemData_q;
        imemDone_d  = 1'b0;
        dmemDone_d  = 1'b0;

        if (grantValid) begin
            ramEn_d     = 1'b1;
            grantDmem_d = grantDmem;
            lastGrant_d = grantDmem ? GRANT_DMEM : GRANT_IMEM;
            if (grantDmem) begin
                ramAddr_d  = dmem_addr[ADDR_WIDTH+1:2];
                isRead_d   = dmem_re;
                ramWe_d    = dmem_we & ~dmem_re;
                size_d     = dmem_input_sel;
                offset_d   = dmem_addr[1:0];
                ramBe_d    = 4'b1111;
                ramWdata_d = dmem_data_out;
                if (!dmem_re) begin
                    case (dmem_input_sel)
                        2'b01: begin
                            ramWdata_d = {2{dmem_data_out[15:0]}};
                            ramBe_d    = dmem_addr[1] ? 4'b0011 : 4'b1100;
                        end
                        2'b10: begin
                            ramWdata_d = {4{dmem_data_out[7:0]}};
                            ramBe_d    = 4'b1000 >> dmem_addr[1:0];
                        end
                        default: begin
                            ramWdata_d = dmem_data_out;
                            ramBe_d    = 4'b1111;
                        end
                    endcase
                end
            end else begin
                ramAddr_d = imem_addr[ADDR_WIDTH+1:2];
                isRead_d  = 1'b1;
                size_d    = 2'b00;
                offset_d  = 2'b00;
                ramBe_d   = 4'b1111;
            end
        end

        if (state_q == CAPTURE) begin
            if (grantDmem_q) begin
                dmemDone_d = 1'b1;
                if (isRead_q) begin
                    dmemData_d = steered;
                end
            end else begin
                imemDone_d = 1'b1;
                imemData_d = steered;
            end
        end
    end

    // Datapath and output registers, all cleared asynchronously by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lastGrant_q <= GRANT_IMEM;
            grantDmem_q <= 1'b0;
            isRead_q    <= 1'b0;
            size_q      <= 2'b00;
            offset_q    <= 2'b00;
            ramAddr_q   <= '0;
            ramEn_q     <= 1'b0;
            ramWe_q     <= 1'b0;
            ramBe_q     <= 4'b0000;
            ramWdata_q  <= 32'h0;
            imemData_q  <= 32'h0;
            dmemData_q  <= 32'h0;
            imemDone_q  <= 1'b0;
            dmemDone_q  <= 1'b0;
        end else begin
            lastGrant_q <= lastGrant_d;
            grantDmem_q <= grantDmem_d;
            isRead_q    <= isRead_d;
            size_q      <= size_d;
            offset_q    <= offset_d;
            ramAddr_q   <= ramAddr_d;
            ramEn_q     <= ramEn_d;
            ramWe_q     <= ramWe_d;
            ramBe_q     <= ramBe_d;
            ramWdata_q  <= ramWdata_d;
            imemData_q  <= imemData_d;
            dmemData_q  <= dmemData_d;
            imemDone_q  <= imemDone_d;
            dmemDone_q  <= dmemDone_d;
        end
    end

    assign ram_addr     = ramAddr_q;
    assign ram_en       = ramEn_q;
    assign ram_we       = ramWe_q;
    assign ram_be       = ramBe_q;
    assign ram_wdata    = ramWdata_q;
    assign imem_data_in = imemData_q;
    assign dmem_data_in = dmemData_q;
    assign imem_done    = imemDone_q;
    assign dmem_done    = dmemDone_q;

endmodule

// File: tb/tb_openfire_mem_ctrl.sv
// Testbench for openfire_mem_ctrl: behavioural single-port RAM, reset and
// round-robin arbitration sequences, a table of single accesses checked
// through an expectation queue, and an abort-by-reset sequence.
module tb_openfire_mem_ctrl;

   typedef struct {
      logic        isDmem;
      logic        re;
      logic        we;
      logic [1:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] expData;
      logic [3:0]  expBe;
      logic        expWe;
      logic [31:0] expWdata;
      logic [11:0] expRamAddr;
      logic        chkMem;
      logic [31:0] memExp;
   } vec_t;

   typedef struct {
      logic        isDmem;
      int          cycle;
      logic [31:0] data;
   } evt_t;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] imem_addr;
   logic        imem_re;
   logic [31:0] imem_data_in;
   logic        imem_done;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_data_out;
   logic        dmem_we;
   logic        dmem_re;
   logic [1:0]  dmem_input_sel;
   logic [31:0] dmem_data_in;
   logic        dmem_done;
   logic [11:0] ram_addr;
   logic        ram_en;
   logic        ram_we;
   logic [3:0]  ram_be;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   logic [31:0] mem [0:4095];
   logic        tbWrEn;
   logic [11:0] tbWrAddr;
   logic [31:0] tbWrData;

   int errors = 0;
   int checks = 0;

   vec_t sbQ[$];
   evt_t arbQ[$];
   vec_t tbl[22];

   int          obsEnCycle;
   int          obsEnCount;
   int          obsDoneCycle;
   int          obsOtherDone;
   logic [31:0] obsData;
   logic [31:0] obsWdata;
   logic [3:0]  obsBe;
   logic        obsWe;
   logic [11:0] obsAddr;
   logic        obsDoneAfter;
   logic        obsEnAfter;

   openfire_mem_ctrl #(.ADDR_WIDTH(12)) dut (
      .clock          (clock),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_re        (imem_re),
      .imem_data_in   (imem_data_in),
      .imem_done      (imem_done),
      .dmem_addr      (dmem_addr),
      .dmem_data_out  (dmem_data_out),
      .dmem_we        (dmem_we),
      .dmem_re        (dmem_re),
      .dmem_input_sel (dmem_input_sel),
      .dmem_data_in   (dmem_data_in),
      .dmem_done      (dmem_done),
      .ram_addr       (ram_addr),
      .ram_en         (ram_en),
      .ram_we         (ram_we),
      .ram_be         (ram_be),
      .ram_wdata      (ram_wdata),
      .ram_rdata      (ram_rdata)
   );

   // Free-running clock, 10 time units per period.
   always #5 clock = ~clock;

   function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                              input logic [31:0] newWord,
                                              input logic [3:0]  be);
      logic [31:0] res;
      res = oldWord;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[b*8 +: 8] = newWord[b*8 +: 8];
      end
      return res;
   endfunction

   // Single-port synchronous RAM with one-cycle read latency and a bench preload port.
   always @(posedge clock) begin
      if (tbWrEn) begin
         mem[tbWrAddr] <= tbWrData;
      end else if (ram_en) begin
         ram_rdata <= mem[ram_addr];
         if (ram_we) mem[ram_addr] <= mergeBytes(mem[ram_addr], ram_wdata, ram_be);
      end
   end

   function automatic vec_t mk(input logic isDmem, input logic re, input logic we,
                               input logic [1:0] sel, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expData,
                               input logic [3:0] expBe, input logic expWe,
                               input logic [31:0] expWdata, input logic [11:0] expRamAddr,
                               input logic chkMem, input logic [31:0] memExp);
      vec_t v;
      v.isDmem = isDmem; v.re = re; v.we = we; v.sel = sel; v.addr = addr;
      v.wdata = wdata; v.expData = expData; v.expBe = expBe; v.expWe = expWe;
      v.expWdata = expWdata; v.expRamAddr = expRamAddr; v.chkMem = chkMem;
      v.memExp = memExp;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [11:0] a, input logic [31:0] d);
      tbWrAddr = a;
      tbWrData = d;
      tbWrEn   = 1'b1;
      @(negedge clock);
      tbWrEn   = 1'b0;
   endtask

   // Drives one request at a negedge, pushes its expectation and observes the access.
   task automatic applyStimulus(input vec_t v);
      int  cyc;
      bit  seen;
      sbQ.push_back(v);
      if (v.isDmem) begin
         dmem_addr      = v.addr;
         dmem_re        = v.re;
         dmem_we        = v.we;
         dmem_input_sel = v.sel;
         dmem_data_out  = v.wdata;
      end else begin
         imem_addr = v.addr;
         imem_re   = 1'b1;
      end
      obsEnCycle = -1; obsEnCount = 0; obsDoneCycle = -1; obsOtherDone = 0;
      obsData = 32'h0; obsWdata = 32'h0; obsBe = 4'h0; obsWe = 1'b0; obsAddr = 12'h0;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 8) begin
         @(negedge clock);
         cyc++;
         if (ram_en) begin
            obsEnCount++;
            obsEnCycle = cyc;
            obsAddr    = ram_addr;
            obsBe      = ram_be;
            obsWe      = ram_we;
            obsWdata   = ram_wdata;
         end
         if (v.isDmem ? imem_done : dmem_done) obsOtherDone++;
         if (v.isDmem ? dmem_done : imem_done) begin
            seen         = 1'b1;
            obsDoneCycle = cyc;
            obsData      = v.isDmem ? dmem_data_in : imem_data_in;
         end
      end
      imem_re = 1'b0;
      dmem_re = 1'b0;
      dmem_we = 1'b0;
      @(negedge clock);
      obsDoneAfter = imem_done | dmem_done;
      obsEnAfter   = ram_en;
   endtask

   // Pops the oldest expectation and compares it against the observed access.
   task automatic checkOutput(input int idx);
      vec_t v;
      if (sbQ.size() == 0) begin
         check($sformatf("v%0d queue", idx), 32'd0, 32'd1);
         return;
      end
      v = sbQ.pop_front();
      check($sformatf("v%0d latency", idx), obsDoneCycle, 3);
      check($sformatf("v%0d enCycle", idx), obsEnCycle, 1);
      check($sformatf("v%0d enCount", idx), obsEnCount, 1);
      check($sformatf("v%0d ramAddr", idx), {20'h0, obsAddr}, {20'h0, v.expRamAddr});
      check($sformatf("v%0d ramBe", idx), {28'h0, obsBe}, {28'h0, v.expBe});
      check($sformatf("v%0d ramWe", idx), {31'h0, obsWe}, {31'h0, v.expWe});
      check($sformatf("v%0d data", idx), obsData, v.expData);
      check($sformatf("v%0d otherDone", idx), obsOtherDone, 0);
      check($sformatf("v%0d doneAfter", idx), {31'h0, obsDoneAfter}, 32'h0);
      check($sformatf("v%0d enAfter", idx), {31'h0, obsEnAfter}, 32'h0);
      if (v.expWe) check($sformatf("v%0d ramWdata", idx), obsWdata, v.expWdata);
      if (v.chkMem) check($sformatf("v%0d memWord", idx), mem[v.expRamAddr], v.memExp);
   endtask

   initial begin
      int   enCount;
      int   doneCount;
      evt_t e;

      reset = 1'b0;
      tbWrEn = 1'b0; tbWrAddr = 12'h0; tbWrData = 32'h0;
      imem_addr = 32'h0; imem_re = 1'b0;
      dmem_addr = 32'h0; dmem_data_out = 32'h0; dmem_we = 1'b0; dmem_re = 1'b0;
      dmem_input_sel = 2'b00;

      @(negedge clock);
      preload(12'd2, 32'h1122_3344);
      preload(12'd3, 32'hDEAD_BEEF);
      preload(12'd5, 32'hB800_0010);

      // Reset held with both ports requesting: nothing may happen.
      imem_addr = 32'h14; imem_re = 1'b1;
      dmem_addr = 32'h8; dmem_re = 1'b1; dmem_input_sel = 2'b00;
      enCount = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         if (ram_en) enCount++;
      end
      check("reset ramEnSeen", enCount, 0);
      check("reset ram_we", {31'h0, ram_we}, 32'h0);
      check("reset ram_be", {28'h0, ram_be}, 32'h0);
      check("reset ram_addr", {20'h0, ram_addr}, 32'h0);
      check("reset ram_wdata", ram_wdata, 32'h0);
      check("reset imem_data_in", imem_data_in, 32'h0);
      check("reset dmem_data_in", dmem_data_in, 32'h0);
      check("reset imem_done", {31'h0, imem_done}, 32'h0);
      check("reset dmem_done", {31'h0, dmem_done}, 32'h0);

      // Release with both requests held: dmem, imem, dmem, imem, dones 4 cycles apart.
      arbQ.push_back('{isDmem: 1'b1, cycle: 3,  data: 32'h1122_3344});
      arbQ.push_back('{isDmem: 1'b0, cycle: 7,  data: 32'hB800_0010});
      arbQ.push_back('{isDmem: 1'b1, cycle: 11, data: 32'h1122_3344});
      arbQ.push_back('{isDmem: 1'b0, cycle: 15, data: 32'hB800_0010});
      reset = 1'b1;
      enCount = 0;
      doneCount = 0;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clock);
         if (ram_en) begin
            enCount++;
            check($sformatf("arb enCycle%0d", enCount), k % 4, 1);
         end
         if (imem_done && dmem_done) check("arb bothDone", 32'd1, 32'd0);
         if (imem_done || dmem_done) begin
            doneCount++;
            if (arbQ.size() == 0) begin
               check("arb extraDone", k, 0);
            end else begin
               e = arbQ.pop_front();
               check($sformatf("arb port%0d", doneCount), {31'h0, dmem_done}, {31'h0, e.isDmem});
               check($sformatf("arb cycle%0d", doneCount), k, e.cycle);
               check($sformatf("arb data%0d", doneCount),
                     dmem_done ? dmem_data_in : imem_data_in, e.data);
            end
         end
         if (k == 15) begin
            imem_re = 1'b0;
            dmem_re = 1'b0;
         end
      end
      check("arb doneCount", doneCount, 4);
      check("arb enCount", enCount, 4);
      @(negedge clock);
      check("arb idleAfter", {31'h0, ram_en | imem_done | dmem_done}, 32'h0);

      // Single-access vectors; ram word 2 = 11223344, 3 = DEADBEEF, 5 = B8000010.
      tbl[0]  = mk(1'b0, 1'b1, 1'b0, 2'b00, 32'h14, 32'h0, 32'hB800_0010, 4'hF, 1'b0, 32'h0, 12'd5, 1'b0, 32'h0);
      tbl[1]  = mk(1'b1, 1'b1, 1'b0, 2'b10, 32'h8,  32'h0, 32'h0000_0011, 4'hF, 1'b0, 32'h0, 12'd2, 1'b0, 32'h0);
      tbl[2]  = mk(1'b1, 1'b1, 1'b0, 2'b10, 32'h9,  32'h0, 32'h0000_0022, 4'hF, 1'b0, 32'h0, 12'd2, 1'b0, 32'h0);
      tbl[3]  = mk(1'b1, 1'b1, 1'b0, 2'b10, 32'hA,  32'h0, 32'h0000_0033, 4'hF, 1'b0, 32'h0, 12'd2, 1'b0, 32'h0);
      tbl[4]  = mk(1'b1, 1'b1, 1'b0, 2'b10, 32'hB,  32'h0, 32'h0000_0044, 4'hF, 1'b0, 32'h0, 12'd2, 1'b0, 32'h0);
      tbl[5]  = mk(1'b1, 1'b1, 1'b0, 2'b01, 32'h8,  32'h0, 32'h0000_1122, 4'hF, 1'b0, 32'h0, 12'd2, 1'b0, 32'h0);
      tbl[6]  = mk(1'b1, 1'b1, 1'b0, 2'b01, 32'hA,  32'h0, 32'h0000_3344, 4'hF, 1'b0, 32'h0, 12'd2, 1'b0, 32'h0);
      tbl[7]  = mk(1'b1, 1'b1, 1'b0, 2'b01, 32'h9,  32'h0, 32'h0000_1122, 4'hF, 1'b0, 32'h0, 12'd2, 1'b0, 32'h0);
      tbl[8]  = mk(1'b1, 1'b1, 1'b0, 2'b00, 32'h8,  32'h0, 32'h1122_3344, 4'hF, 1'b0, 32'h0, 12'd2, 1'b0, 32'h0);
      tbl[9]  = mk(1'b1, 1'b1, 1'b0, 2'b11, 32'hB,  32'h0, 32'h1122_3344, 4'hF, 1'b0, 32'h0, 12'd2, 1'b0, 32'h0);
      tbl[10] = mk(1'b1, 1'b0, 1'b1, 2'b10, 32'h9,  32'hFFFF_FFAB, 32'h1122_3344, 4'b0100, 1'b1, 32'hABAB_ABAB, 12'd2, 1'b1, 32'h11AB_3344);
      tbl[11] = mk(1'b1, 1'b0, 1'b1, 2'b01, 32'hA,  32'h1234_CDEF, 32'h1122_3344, 4'b0011, 1'b1, 32'hCDEF_CDEF, 12'd2, 1'b1, 32'h11AB_CDEF);
      tbl[12] = mk(1'b1, 1'b1, 1'b0, 2'b00, 32'h8,  32'h0, 32'h11AB_CDEF, 4'hF, 1'b0, 32'h0, 12'd2, 1'b0, 32'h0);
      tbl[13] = mk(1'b1, 1'b1, 1'b1, 2'b00, 32'hC,  32'h1234_5678, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 12'd3, 1'b1, 32'hDEAD_BEEF);
      tbl[14] = mk(1'b1, 1'b0, 1'b1, 2'b00, 32'h10, 32'hCAFE_F00D, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'hCAFE_F00D, 12'd4, 1'b1, 32'hCAFE_F00D);
      tbl[15] = mk(1'b1, 1'b0, 1'b1, 2'b10, 32'h10, 32'h0000_0077, 32'hDEAD_BEEF, 4'b1000, 1'b1, 32'h7777_7777, 12'd4, 1'b1, 32'h77FE_F00D);
      tbl[16] = mk(1'b1, 1'b0, 1'b1, 2'b10, 32'h13, 32'h0000_0099, 32'hDEAD_BEEF, 4'b0001, 1'b1, 32'h9999_9999, 12'd4, 1'b1, 32'h77FE_F099);
      tbl[17] = mk(1'b1, 1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 32'h77FE_F099, 4'hF, 1'b0, 32'h0, 12'd4, 1'b0, 32'h0);
      tbl[18] = mk(1'b0, 1'b1, 1'b0, 2'b00, 32'h4014, 32'h0, 32'hB800_0010, 4'hF, 1'b0, 32'h0, 12'd5, 1'b0, 32'h0);
      tbl[19] = mk(1'b1, 1'b1, 1'b0, 2'b10, 32'h400B, 32'h0, 32'h0000_00EF, 4'hF, 1'b0, 32'h0, 12'd2, 1'b0, 32'h0);
      tbl[20] = mk(1'b0, 1'b1, 1'b0, 2'b00, 32'h14, 32'h0, 32'hB800_0010, 4'hF, 1'b0, 32'h0, 12'd5, 1'b0, 32'h0);
      tbl[21] = mk(1'b1, 1'b1, 1'b0, 2'b00, 32'h8,  32'h0, 32'h11AB_CDEF, 4'hF, 1'b0, 32'h0, 12'd2, 1'b0, 32'h0);

      for (int i = 0; i < 20; i++) begin
         applyStimulus(tbl[i]);
         checkOutput(i);
      end

      // Reset asserted during CAPTURE of a dmem read aborts it without a done.
      dmem_addr = 32'h8; dmem_re = 1'b1; dmem_input_sel = 2'b00;
      @(negedge clock);
      check("abort issueEn", {31'h0, ram_en}, 32'h1);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("abort ram_en", {31'h0, ram_en}, 32'h0);
      check("abort dmem_done", {31'h0, dmem_done}, 32'h0);
      check("abort dmem_data_in", dmem_data_in, 32'h0);
      dmem_re = 1'b0;
      doneCount = 0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         if (imem_done || dmem_done || ram_en) doneCount++;
      end
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         if (imem_done || dmem_done || ram_en) doneCount++;
      end
      check("abort quiet", doneCount, 0);

      for (int i = 20; i < 22; i++) begin
         applyStimulus(tbl[i]);
         checkOutput(i);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
